// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle sequencer for the single-issue RV32I core: fetch, decode qualify,
// execute capture, data-memory handshake and writeback, one instruction in flight.
module riscv_mc_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        dec_en_o,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic        is_branch_i,
  input  logic        is_jump_i,
  input  logic        is_ecall_i,
  input  logic        br_taken_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] target_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        rf_write_en_o,
  output logic [4:0]  rf_write_reg_o,
  output logic [31:0] rf_write_data_o,
  output logic [31:0] pc_o,
  output logic [31:0] instret_o,
  output logic        halted_o,
  output logic [1:0]  err_o
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   instret_q, instret_d;
  logic [1:0]    err_q, err_d;
  logic [31:0]   alu_q, alu_d;
  logic [31:0]   tgt_q, tgt_d;
  logic [31:0]   ld_q, ld_d;
  logic          taken_q, taken_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic        timeout_hit;

  assign pc_plus4    = pc_q + 32'd4;
  // The counter holds the number of request cycles already spent without an ack.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instret_d     = instret_q;
    err_d         = err_q;
    alu_d         = alu_q;
    tgt_d         = tgt_q;
    ld_d          = ld_q;
    taken_d       = taken_q;
    cnt_d         = '0;
    imem_req_o    = 1'b0;
    dmem_req_o    = 1'b0;
    dmem_we_o     = 1'b0;
    dec_en_o      = 1'b0;
    rf_write_en_o = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          err_d   = 2'b10;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: begin
        dec_en_o = 1'b1;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        alu_d   = alu_result_i;
        tgt_d   = is_jump_i ? (target_i & ~32'd1) : target_i;
        taken_d = is_jump_i | (is_branch_i & br_taken_i);
        if (is_ecall_i) begin
          instret_d = instret_q + 32'd1;
          state_d   = S_HALT;
        end else if (taken_d && (tgt_d[1:0] != 2'b00)) begin
          err_d   = 2'b01;
          state_d = S_HALT;
        end else if (is_load_i || is_store_i) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = is_store_i;
        if (dmem_ack_i) begin
          if (is_store_i) begin
            pc_d      = pc_plus4;
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
          end else begin
            ld_d    = dmem_rdata_i;
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          err_d   = 2'b11;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB: begin
        rf_write_en_o = (instr_q[11:7] != 5'd0) && !is_branch_i && !is_store_i;
        pc_d          = taken_q ? tgt_q : pc_plus4;
        instret_d     = instret_q + 32'd1;
        state_d       = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Nothing may be requested or strobed while reset is being applied.
    if (rst_i) begin
      imem_req_o    = 1'b0;
      dmem_req_o    = 1'b0;
      dmem_we_o     = 1'b0;
      dec_en_o      = 1'b0;
      rf_write_en_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      instret_q <= '0;
      err_q     <= 2'b00;
      alu_q     <= '0;
      tgt_q     <= '0;
      ld_q      <= '0;
      taken_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      err_q     <= err_d;
      alu_q     <= alu_d;
      tgt_q     <= tgt_d;
      ld_q      <= ld_d;
      taken_q   <= taken_d;
      cnt_q     <= cnt_d;
    end
  end

  assign imem_addr_o     = pc_q;
  assign instr_o         = instr_q;
  assign dmem_addr_o     = alu_q;
  assign rf_write_reg_o  = instr_q[11:7];
  assign rf_write_data_o = is_jump_i ? pc_plus4 : (is_load_i ? ld_q : alu_q);
  assign pc_o            = pc_q;
  assign instret_o       = instret_q;
  assign halted_o        = (state_q == S_HALT);
  assign err_o           = err_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed bench for riscv_mc_ctrl: drives fetch/decode/memory responses cycle by
// cycle and compares outputs against hand-computed values.
module tb_riscv_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, dec_en;
  logic [31:0] imem_addr, imem_rdata, instr, dmem_addr, dmem_rdata;
  logic        is_load, is_store, is_branch, is_jump, is_ecall, br_taken;
  logic [31:0] alu_result, target;
  logic        rf_write_en;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data, pc, instret;
  logic        halted;
  logic [1:0]  err;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  riscv_mc_ctrl #(.RESET_PC(32'h0), .MEM_TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack),
    .imem_rdata_i(imem_rdata), .instr_o(instr), .dec_en_o(dec_en),
    .is_load_i(is_load), .is_store_i(is_store), .is_branch_i(is_branch),
    .is_jump_i(is_jump), .is_ecall_i(is_ecall), .br_taken_i(br_taken),
    .alu_result_i(alu_result), .target_i(target),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_ack_i(dmem_ack), .dmem_rdata_i(dmem_rdata),
    .rf_write_en_o(rf_write_en), .rf_write_reg_o(rf_write_reg),
    .rf_write_data_o(rf_write_data), .pc_o(pc), .instret_o(instret),
    .halted_o(halted), .err_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic ld, st, br, jp, ec, bt, input logic [31:0] alu, tgt);
    is_load = ld; is_store = st; is_branch = br; is_jump = jp; is_ecall = ec;
    br_taken = bt; alu_result = alu; target = tgt;
  endtask

  // FETCH (ack in first cycle), DECODE, EXEC.
  task automatic fde(input logic [31:0] ins, pc_exp, input logic ld, st, br, jp, ec, bt,
                     input logic [31:0] alu, tgt);
    imem_ack = 1'b1; imem_rdata = ins;
    #1;
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, pc_exp);
    tick;
    imem_ack = 1'b0; imem_rdata = '0;
    set_dec(ld, st, br, jp, ec, bt, alu, tgt);
    #1;
    chk("dec_en", dec_en, 1);
    chk("instr", instr, ins);
    chk("dec_imem_req", imem_req, 0);
    tick;
    #1;
    chk("exec_dec_en", dec_en, 0);
    chk("exec_rf_we", rf_write_en, 0);
    tick;
  endtask

  task automatic mem_ph(input logic we, input logic [31:0] addr, input int dlat,
                        input logic [31:0] rdata);
    for (int i = 1; i <= dlat; i++) begin
      if (i == dlat) begin
        dmem_ack = 1'b1; dmem_rdata = rdata;
      end
      #1;
      chk("mem_req", dmem_req, 1);
      chk("mem_we", dmem_we, we);
      chk("mem_addr", dmem_addr, addr);
      tick;
      dmem_ack = 1'b0; dmem_rdata = '0;
    end
  endtask

  task automatic wb_ph(input logic en, input logic [4:0] rd, input logic [31:0] data);
    #1;
    chk("wb_we", rf_write_en, en);
    if (en) begin
      chk("wb_reg", rf_write_reg, rd);
      chk("wb_data", rf_write_data, data);
    end
    tick;
  endtask

  task automatic at_fetch(input logic [31:0] pc_exp, cnt_exp);
    #1;
    chk("nxt_imem_req", imem_req, 1);
    chk("nxt_pc", pc, pc_exp);
    chk("nxt_instret", instret, cnt_exp);
    chk("nxt_rf_we", rf_write_en, 0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    tick;
    rst = 1'b0;
  endtask

  initial begin
    imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    set_dec(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    tick;
    tick;
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dec_en", dec_en, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 2'b00);
    chk("rst_instr", instr, 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_req", imem_req, 1);

    // addi x1,x0,5
    fde(32'h0050_0093, 32'h0, 0, 0, 0, 0, 0, 0, 32'd5, 32'h0);
    wb_ph(1, 5'd1, 32'd5);
    at_fetch(32'h4, 32'd1);

    // lw x2,0x100(x0), ack on third MEM cycle
    fde(32'h1000_2103, 32'h4, 1, 0, 0, 0, 0, 0, 32'h100, 32'h0);
    mem_ph(1'b0, 32'h100, 3, 32'hDEAD_BEEF);
    wb_ph(1, 5'd2, 32'hDEAD_BEEF);
    at_fetch(32'h8, 32'd2);

    // sw retires straight from MEM
    fde(32'h0011_2223, 32'h8, 0, 1, 0, 0, 0, 0, 32'h200, 32'h0);
    mem_ph(1'b1, 32'h200, 1, 32'h0);
    at_fetch(32'hC, 32'd3);

    // beq taken, then not taken
    fde(32'h0000_0463, 32'hC, 0, 0, 1, 0, 0, 1, 32'h0, 32'h40);
    wb_ph(0, 5'd0, 32'h0);
    at_fetch(32'h40, 32'd4);
    fde(32'h0000_0463, 32'h40, 0, 0, 1, 0, 0, 0, 32'h0, 32'h80);
    wb_ph(0, 5'd0, 32'h0);
    at_fetch(32'h44, 32'd5);

    // jalr x1 with odd target: bit 0 cleared, link = pc+4
    fde(32'h0250_00E7, 32'h44, 0, 0, 0, 1, 0, 0, 32'h25, 32'h25);
    wb_ph(1, 5'd1, 32'h48);
    at_fetch(32'h24, 32'd6);

    // rd = x0 suppresses the write but still retires
    fde(32'h0000_0013, 32'h24, 0, 0, 0, 0, 0, 0, 32'h99, 32'h0);
    wb_ph(0, 5'd0, 32'h0);
    at_fetch(32'h28, 32'd7);

    // jal to 0x22: misaligned, halt with pc held and no retire
    fde(32'h0000_00EF, 32'h28, 0, 0, 0, 1, 0, 0, 32'h0, 32'h22);
    #1;
    chk("mis_halted", halted, 1);
    chk("mis_err", err, 2'b01);
    chk("mis_pc", pc, 32'h28);
    chk("mis_instret", instret, 32'd7);
    chk("mis_imem_req", imem_req, 0);
    chk("mis_rf_we", rf_write_en, 0);
    imem_ack = 1'b1;
    tick;
    tick;
    #1;
    chk("halt_pc_frozen", pc, 32'h28);
    chk("halt_stays", halted, 1);
    chk("halt_no_req", imem_req, 0);
    imem_ack = 1'b0;

    // ecall: halts with no error and counts as retired
    do_reset;
    #1;
    chk("rst2_pc", pc, 32'h0);
    chk("rst2_halted", halted, 0);
    chk("rst2_err", err, 2'b00);
    fde(32'h0000_0073, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    #1;
    chk("ecall_halted", halted, 1);
    chk("ecall_err", err, 2'b00);
    chk("ecall_instret", instret, 32'd1);
    chk("ecall_pc", pc, 32'h0);

    // imem timeout after four unanswered request cycles
    do_reset;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_imem_req", imem_req, 1);
      chk("to_imem_halted", halted, 0);
      tick;
    end
    #1;
    chk("imem_to_halted", halted, 1);
    chk("imem_to_err", err, 2'b10);
    chk("imem_to_req", imem_req, 0);

    // dmem timeout
    do_reset;
    fde(32'h1000_2103, 32'h0, 1, 0, 0, 0, 0, 0, 32'h100, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_dmem_req", dmem_req, 1);
      tick;
    end
    #1;
    chk("dmem_to_halted", halted, 1);
    chk("dmem_to_err", err, 2'b11);
    chk("dmem_to_req", dmem_req, 0);

    // reset in the middle of MEM, with a late ack arriving afterwards
    do_reset;
    fde(32'h1000_2103, 32'h0, 1, 0, 0, 0, 0, 0, 32'h100, 32'h0);
    #1;
    chk("pre_rst_dmem_req", dmem_req, 1);
    tick;
    rst = 1'b1;
    #1;
    chk("mid_rst_dmem_req", dmem_req, 0);
    tick;
    rst = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1234_5678;
    #1;
    chk("after_rst_imem_req", imem_req, 1);
    chk("after_rst_dmem_req", dmem_req, 0);
    chk("after_rst_pc", pc, 32'h0);
    chk("after_rst_halted", halted, 0);
    tick;
    dmem_ack = 1'b0;
    #1;
    chk("late_ack_imem_req", imem_req, 1);
    chk("late_ack_dmem_req", dmem_req, 0);
    chk("late_ack_instret", instret, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
